// File: rtl/sc_level_pacer_pkg.sv
// Shared encodings and constant helpers for the level pacer.
package sc_level_pacer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_BANNER = 2'd2,
    ST_DONE   = 2'd3
  } pacer_state_e;

  // Width of a stage index; a single stage still needs one bit.
  function automatic int unsigned stage_width(input int unsigned stages);
    int unsigned w;
    w = (stages <= 32'd2) ? 32'd1 : 32'($clog2(stages));
    return w;
  endfunction

  // Load period of a stage, in clocks.
  function automatic int unsigned period_of(input int unsigned base,
                                            input int unsigned step,
                                            input int unsigned stage);
    return base - stage * step;
  endfunction

endpackage

// File: rtl/sc_tick_counter.sv
// Loadable down counter; flags the terminal count while enabled.
module sc_tick_counter #(
  parameter int unsigned               PERIOD_WIDTH = 25,
  parameter logic [PERIOD_WIDTH-1:0]   RESET_VALUE  = '0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    reload,
  input  logic [PERIOD_WIDTH-1:0] reload_val,
  output logic                    tick_c
);

  logic [PERIOD_WIDTH-1:0] count_q;

  // Explicit reload wins over counting; terminal count reloads itself.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= RESET_VALUE;
    end else if (reload) begin
      count_q <= reload_val;
    end else if (en) begin
      if (count_q == '0) begin
        count_q <= reload_val;
      end else begin
        count_q <= count_q - PERIOD_WIDTH'(1);
      end
    end
  end

  assign tick_c = en && (count_q == '0);

endmodule

// File: rtl/sc_level_pacer.sv
// Level-driven speed pacer: stage decode, load pulses, promotion banner.
module sc_level_pacer
  import sc_level_pacer_pkg::*;
#(
  parameter int unsigned LEVEL_WIDTH      = 8,
  parameter int unsigned STAGES           = 3,
  parameter int unsigned LEVELS_PER_STAGE = 16,
  parameter int unsigned PERIOD_WIDTH     = 25,
  parameter int unsigned BASE_PERIOD      = 17500000,
  parameter int unsigned PERIOD_STEP      = 2500000,
  parameter int unsigned BANNER_TICKS     = 4
) (
  input  logic                             SC_LEVELPACER_CLOCK_50,
  input  logic                             SC_LEVELPACER_RESET_InHigh,
  input  logic                             SC_LEVELPACER_START_InLow,
  input  logic                             SC_LEVELPACER_PAUSE_InHigh,
  input  logic [LEVEL_WIDTH-1:0]           SC_LEVELPACER_LEVEL_In,
  output logic                             SC_LEVELPACER_LOAD_Out,
  output logic [stage_width(STAGES)-1:0]   SC_LEVELPACER_STAGE_Out,
  output logic                             SC_LEVELPACER_BANNER_Out,
  output logic                             SC_LEVELPACER_DONE_Out,
  output logic [PERIOD_WIDTH-1:0]          SC_LEVELPACER_PERIOD_Out
);

  localparam int unsigned SW = stage_width(STAGES);
  localparam int unsigned BW = (BANNER_TICKS < 32'd2) ? 32'd1 : 32'($clog2(BANNER_TICKS + 1));
  localparam longint LAST_PERIOD =
    longint'(BASE_PERIOD) - longint'(STAGES - 1) * longint'(PERIOD_STEP);

  // Parameter sanity at elaboration.
  if (STAGES < 2) begin : g_chk_stages
    $error("sc_level_pacer: STAGES must be at least 2");
  end
  if (LAST_PERIOD < 2) begin : g_chk_period
    $error("sc_level_pacer: last stage period must be at least 2");
  end
  if (longint'(BASE_PERIOD) >= (longint'(1) << PERIOD_WIDTH)) begin : g_chk_width
    $error("sc_level_pacer: BASE_PERIOD does not fit PERIOD_WIDTH");
  end

  pacer_state_e            state_q, state_d;
  logic [SW-1:0]           stage_q, stage_d;
  logic [BW-1:0]           ban_cnt_q, ban_cnt_d;
  logic [LEVEL_WIDTH-1:0]  level_q;
  logic                    load_q, load_d;
  logic                    banner_q, done_q;
  logic [PERIOD_WIDTH-1:0] period_q;
  logic [SW-1:0]           lvl_stage_c;
  logic                    lvl_final_c;
  logic                    ctr_en_c, ctr_reload_c, tick_c;
  logic [PERIOD_WIDTH-1:0] ctr_reload_val_c;
  logic [PERIOD_WIDTH-1:0] period_tbl [STAGES];

  // Constant per-stage period table.
  for (genvar g = 0; g < STAGES; g++) begin : g_period
    assign period_tbl[g] = PERIOD_WIDTH'(period_of(BASE_PERIOD, PERIOD_STEP, g));
  end

  // Stage decode as a threshold chain over the registered level.
  always_comb begin
    lvl_stage_c = '0;
    for (int unsigned s = 1; s < STAGES; s++) begin
      if (32'(level_q) >= s * LEVELS_PER_STAGE) lvl_stage_c = SW'(s);
    end
  end

  assign lvl_final_c = 32'(level_q) >= STAGES * LEVELS_PER_STAGE;

  // Counter runs only in the undisturbed RUN/BANNER case.
  assign ctr_en_c = ((state_q == ST_RUN) || (state_q == ST_BANNER)) &&
                    !SC_LEVELPACER_PAUSE_InHigh && !lvl_final_c &&
                    (lvl_stage_c == stage_q);

  assign ctr_reload_val_c = period_tbl[stage_d] - PERIOD_WIDTH'(1);

  // Next-state, stage and banner-count logic in priority order.
  always_comb begin
    state_d      = state_q;
    stage_d      = stage_q;
    ban_cnt_d    = ban_cnt_q;
    load_d       = 1'b0;
    ctr_reload_c = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (!SC_LEVELPACER_START_InLow) begin
          stage_d      = lvl_stage_c;
          ctr_reload_c = 1'b1;
          state_d      = lvl_final_c ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN, ST_BANNER: begin
        if (SC_LEVELPACER_PAUSE_InHigh) begin
          state_d = state_q;
        end else if (lvl_final_c) begin
          state_d = ST_DONE;
        end else if (lvl_stage_c > stage_q) begin
          stage_d      = lvl_stage_c;
          ctr_reload_c = 1'b1;
          ban_cnt_d    = '0;
          state_d      = ST_BANNER;
        end else if (lvl_stage_c < stage_q) begin
          stage_d      = lvl_stage_c;
          ctr_reload_c = 1'b1;
          state_d      = ST_RUN;
        end else if (state_q == ST_RUN) begin
          load_d = tick_c;
        end else if (tick_c) begin
          if (ban_cnt_q == BW'(BANNER_TICKS - 1)) begin
            state_d      = ST_RUN;
            ctr_reload_c = 1'b1;
          end else begin
            ban_cnt_d = ban_cnt_q + BW'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge SC_LEVELPACER_CLOCK_50) begin
    if (SC_LEVELPACER_RESET_InHigh) begin
      state_q   <= ST_IDLE;
      stage_q   <= '0;
      ban_cnt_q <= '0;
      level_q   <= '0;
      load_q    <= 1'b0;
      banner_q  <= 1'b0;
      done_q    <= 1'b0;
      period_q  <= PERIOD_WIDTH'(BASE_PERIOD);
    end else begin
      state_q   <= state_d;
      stage_q   <= stage_d;
      ban_cnt_q <= ban_cnt_d;
      level_q   <= SC_LEVELPACER_LEVEL_In;
      load_q    <= load_d;
      banner_q  <= (state_d == ST_BANNER);
      done_q    <= (state_d == ST_DONE);
      period_q  <= period_tbl[stage_d];
    end
  end

  sc_tick_counter #(
    .PERIOD_WIDTH (PERIOD_WIDTH),
    .RESET_VALUE  (PERIOD_WIDTH'(BASE_PERIOD - 1))
  ) u_tick_counter (
    .clk        (SC_LEVELPACER_CLOCK_50),
    .rst        (SC_LEVELPACER_RESET_InHigh),
    .en         (ctr_en_c),
    .reload     (ctr_reload_c),
    .reload_val (ctr_reload_val_c),
    .tick_c     (tick_c)
  );

  assign SC_LEVELPACER_LOAD_Out   = load_q;
  assign SC_LEVELPACER_STAGE_Out  = stage_q;
  assign SC_LEVELPACER_BANNER_Out = banner_q;
  assign SC_LEVELPACER_DONE_Out   = done_q;
  assign SC_LEVELPACER_PERIOD_Out = period_q;

endmodule

// File: tb/tb_sc_level_pacer.sv
// Directed bench for sc_level_pacer with small periods.
module tb_sc_level_pacer;

  localparam int unsigned LW  = 8;
  localparam int unsigned PW  = 8;
  localparam int unsigned SWB = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start_n = 1'b1;
  logic          pause = 1'b0;
  logic [LW-1:0] level = '0;
  logic          load;
  logic [SWB-1:0] stage;
  logic          banner;
  logic          done;
  logic [PW-1:0] period;

  int checks = 0;
  int errors = 0;

  sc_level_pacer #(
    .LEVEL_WIDTH      (LW),
    .STAGES           (3),
    .LEVELS_PER_STAGE (4),
    .PERIOD_WIDTH     (PW),
    .BASE_PERIOD      (10),
    .PERIOD_STEP      (3),
    .BANNER_TICKS     (2)
  ) dut (
    .SC_LEVELPACER_CLOCK_50     (clk),
    .SC_LEVELPACER_RESET_InHigh (rst),
    .SC_LEVELPACER_START_InLow  (start_n),
    .SC_LEVELPACER_PAUSE_InHigh (pause),
    .SC_LEVELPACER_LEVEL_In     (level),
    .SC_LEVELPACER_LOAD_Out     (load),
    .SC_LEVELPACER_STAGE_Out    (stage),
    .SC_LEVELPACER_BANNER_Out   (banner),
    .SC_LEVELPACER_DONE_Out     (done),
    .SC_LEVELPACER_PERIOD_Out   (period)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one edge; outputs are then sampled 1 ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Cycles until the next LOAD pulse, bounded.
  task automatic wait_load(input string tag, input int exp);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!load && n < 64);
    chk(tag, 32'(n), 32'(exp));
  endtask

  // Length of the current banner window; no LOAD may appear in it.
  task automatic banner_len(input string tag, input int exp);
    int n;
    int loads;
    n = 0;
    loads = 0;
    do begin
      step();
      n++;
      if (load) loads++;
    end while (banner && n < 64);
    chk(tag, 32'(n), 32'(exp));
    chk({tag, "_noload"}, 32'(loads), 32'd0);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_load"},   32'(load),   32'd0);
    chk({tag, "_stage"},  32'(stage),  32'd0);
    chk({tag, "_banner"}, 32'(banner), 32'd0);
    chk({tag, "_done"},   32'(done),   32'd0);
    chk({tag, "_period"}, 32'(period), 32'd10);
  endtask

  initial begin
    int loads;
    // 1: reset, start at level 0, stage-0 cadence
    step();
    step();
    chk_reset("rst");
    rst = 1'b0;
    start_n = 1'b0;
    step();
    start_n = 1'b1;
    chk("t1_stage", 32'(stage), 32'd0);
    chk("t1_period", 32'(period), 32'd10);
    chk("t1_load0", 32'(load), 32'd0);
    wait_load("t1_load1", 10);
    wait_load("t1_load2", 10);
    wait_load("t1_load3", 10);

    // 2: promotion to stage 1 with banner
    level = 8'd4;
    step();
    chk("t2_latency", 32'(banner), 32'd0);
    step();
    chk("t2_banner", 32'(banner), 32'd1);
    chk("t2_stage", 32'(stage), 32'd1);
    chk("t2_period", 32'(period), 32'd7);
    banner_len("t2_blen", 14);
    wait_load("t2_load1", 7);
    wait_load("t2_load2", 7);

    // 3: demote to stage 0, then pause mid-period
    level = 8'd0;
    step();
    step();
    chk("t3_stage", 32'(stage), 32'd0);
    chk("t3_period", 32'(period), 32'd10);
    chk("t3_banner", 32'(banner), 32'd0);
    repeat (3) step();
    pause = 1'b1;
    loads = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (load) loads++;
    end
    pause = 1'b0;
    chk("t3_pause_noload", 32'(loads), 32'd0);
    wait_load("t3_delayed", 7);
    wait_load("t3_next", 10);

    // 4: two-stage jump, then final level and restart
    level = 8'd1;
    step();
    step();
    chk("t4_lvl1_stage", 32'(stage), 32'd0);
    level = 8'd9;
    step();
    step();
    chk("t4_banner", 32'(banner), 32'd1);
    chk("t4_stage", 32'(stage), 32'd2);
    chk("t4_period", 32'(period), 32'd4);
    banner_len("t4_blen", 8);
    level = 8'd12;
    step();
    chk("t4_done_lat", 32'(done), 32'd0);
    step();
    chk("t4_done", 32'(done), 32'd1);
    chk("t4_done_banner", 32'(banner), 32'd0);
    loads = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (load) loads++;
    end
    chk("t4_done_noload", 32'(loads), 32'd0);
    chk("t4_done_hold", 32'(done), 32'd1);
    level = 8'd9;
    step();
    start_n = 1'b0;
    step();
    start_n = 1'b1;
    chk("t4_restart_done", 32'(done), 32'd0);
    chk("t4_restart_stage", 32'(stage), 32'd2);
    wait_load("t4_restart_load", 4);

    // 5: level drop to stage 0, no banner; START held low in RUN
    level = 8'd2;
    step();
    chk("t5_latency", 32'(stage), 32'd2);
    step();
    chk("t5_stage", 32'(stage), 32'd0);
    chk("t5_banner", 32'(banner), 32'd0);
    chk("t5_period", 32'(period), 32'd10);
    start_n = 1'b0;
    wait_load("t5_load", 10);
    start_n = 1'b1;

    // 5b: promotion landing on a tick discards that LOAD
    repeat (8) step();
    level = 8'd4;
    step();
    chk("t5b_pre", 32'(load), 32'd0);
    step();
    chk("t5b_discard", 32'(load), 32'd0);
    chk("t5b_banner", 32'(banner), 32'd1);
    chk("t5b_stage", 32'(stage), 32'd1);

    // 6: reset during paused banner
    pause = 1'b1;
    repeat (3) step();
    chk("t6_frozen", 32'(banner), 32'd1);
    rst = 1'b1;
    step();
    chk_reset("t6_rst");
    rst = 1'b0;
    pause = 1'b0;
    loads = 0;
    for (int i = 0; i < 15; i++) begin
      step();
      if (load) loads++;
    end
    chk("t6_idle_noload", 32'(loads), 32'd0);
    chk("t6_idle_banner", 32'(banner), 32'd0);
    start_n = 1'b0;
    step();
    start_n = 1'b1;
    chk("t6_start_stage", 32'(stage), 32'd1);
    chk("t6_start_banner", 32'(banner), 32'd0);
    chk("t6_start_period", 32'(period), 32'd7);
    wait_load("t6_start_load", 7);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global guard against a stalled run.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
